// File: rtl/str_match_engine.sv
// String/pattern matcher: stores a string (up to 32 chars) and a pattern (up to 8 chars),
// then scans start positions one per cycle. Define SME_STAR_EN to compile '*' wildcard support.
module str_match_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  input  logic       isstring,
  input  logic       ispattern,
  output logic       valid,
  output logic       match,
  output logic [4:0] match_index
);

  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_SPACE  = 8'h20;
`ifdef SME_STAR_EN
  localparam logic [7:0] CH_STAR   = 8'h2A;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_STR,
    ST_LOAD_PAT,
    ST_SEARCH,
    ST_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] str_len_q, str_len_d;
  logic [3:0] pat_len_q, pat_len_d;
  logic [4:0] pos_q, pos_d;
  logic       found_q, found_d;

  logic [7:0] str_mem_q [32];
  logic [7:0] pat_mem_q [8];
  logic       str_we, pat_we;
  logic [4:0] str_waddr;
  logic [2:0] pat_waddr;

  // Pattern decode: optional anchors around a core of literal/wildcard characters.
  logic       caret, dollar;
  logic [2:0] pat_last;
  logic [3:0] core_len;
  logic [7:0] core [8];

  always_comb begin
    pat_last = pat_len_q[2:0] - 3'd1;
    caret    = (pat_len_q != 4'd0) && (pat_mem_q[0] == CH_CARET);
    dollar   = (pat_len_q > {3'b000, caret}) && (pat_mem_q[pat_last] == CH_DOLLAR);
    core_len = pat_len_q - {3'b000, caret} - {3'b000, dollar};
    for (int i = 0; i < 8; i++) begin
      core[i] = pat_mem_q[i];
      if (caret) core[i] = (i < 7) ? pat_mem_q[3'(i + 1)] : 8'h00;
    end
  end

  logic       has_star;
  logic [2:0] star_pos;
  logic [5:0] gap;

`ifdef SME_STAR_EN
  logic [5:0] gap_q, gap_d;

  // Only the first '*' in the core acts as a wildcard.
  always_comb begin
    has_star = 1'b0;
    star_pos = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if ((4'(i) < core_len) && (core[i] == CH_STAR)) begin
        has_star = 1'b1;
        star_pos = 3'(i);
      end
    end
  end

  assign gap = gap_q;
`else
  assign has_star = 1'b0;
  assign star_pos = 3'd0;
  assign gap      = 6'd0;
`endif

  // The star itself consumes no character, so it does not count toward the minimum length.
  logic [3:0] need_len;
  logic       no_search;

  assign need_len  = core_len - {3'b000, has_star};
  assign no_search = (str_len_q == 6'd0) || ({2'b00, need_len} > str_len_q);

  // Candidate check for start position pos_q (and star gap length 'gap').
  logic [7:0] cand_ok;
  logic       caret_ok, dollar_ok, cand_hit;
  logic [6:0] end_pos;

  always_comb begin
    logic [6:0] idx;
    cand_ok = '1;
    for (int i = 0; i < 8; i++) begin
      idx = 7'(pos_q) + 7'(i);
      if (has_star && (3'(i) > star_pos)) idx = idx + 7'(gap) - 7'd1;
      if ((4'(i) < core_len) && !(has_star && (3'(i) == star_pos))) begin
        cand_ok[i] = (idx < 7'(str_len_q)) &&
                     ((core[i] == CH_DOT) || (str_mem_q[idx[4:0]] == core[i]));
      end
    end
    caret_ok  = !caret || (pos_q == 5'd0) || (str_mem_q[pos_q - 5'd1] == CH_SPACE);
    end_pos   = 7'(pos_q) + 7'(core_len) + (has_star ? (7'(gap) - 7'd1) : 7'd0);
    dollar_ok = !dollar || (end_pos == 7'(str_len_q)) ||
                ((end_pos < 7'(str_len_q)) && (str_mem_q[end_pos[4:0]] == CH_SPACE));
    cand_hit  = (&cand_ok) && caret_ok && dollar_ok;
  end

  logic pos_last, gap_last, scan_last;

  assign pos_last  = (6'(pos_q) == (str_len_q - 6'd1));
  assign gap_last  = ((6'(pos_q) + gap) >= str_len_q);
  assign scan_last = pos_last && (!has_star || gap_last);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    str_len_d = str_len_q;
    pat_len_d = pat_len_q;
    pos_d     = pos_q;
    found_d   = found_q;
    str_we    = 1'b0;
    str_waddr = str_len_q[4:0];
    pat_we    = 1'b0;
    pat_waddr = pat_len_q[2:0];
`ifdef SME_STAR_EN
    gap_d     = gap_q;
`endif
    case (state_q)
      ST_IDLE, ST_LOAD_STR: begin
        if (isstring) begin
          state_d = ST_LOAD_STR;
          if (state_q != ST_LOAD_STR) begin
            // First string character after a gap starts a fresh string.
            str_we    = 1'b1;
            str_waddr = 5'd0;
            str_len_d = 6'd1;
          end else if (str_len_q < 6'd32) begin
            str_we    = 1'b1;
            str_len_d = str_len_q + 6'd1;
          end
        end else if (ispattern) begin
          state_d   = ST_LOAD_PAT;
          pat_we    = 1'b1;
          pat_waddr = 3'd0;
          pat_len_d = 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_PAT: begin
        if (!ispattern) begin
          state_d = ST_SEARCH;
          pos_d   = 5'd0;
          found_d = 1'b0;
`ifdef SME_STAR_EN
          gap_d   = 6'd0;
`endif
        end else if (isstring) begin
          state_d   = ST_LOAD_STR;
          str_we    = 1'b1;
          str_waddr = 5'd0;
          str_len_d = 6'd1;
        end else if (pat_len_q < 4'd8) begin
          pat_we    = 1'b1;
          pat_len_d = pat_len_q + 4'd1;
        end
      end
      ST_SEARCH: begin
        if (no_search) begin
          state_d = ST_DONE;
        end else if (cand_hit) begin
          found_d = 1'b1;
          state_d = ST_DONE;
        end else if (scan_last) begin
          state_d = ST_DONE;
        end else begin
`ifdef SME_STAR_EN
          if (has_star && !gap_last) begin
            gap_d = gap_q + 6'd1;
          end else begin
            gap_d = 6'd0;
            pos_d = pos_q + 5'd1;
          end
`else
          pos_d = pos_q + 5'd1;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      str_len_q <= 6'd0;
      pat_len_q <= 4'd0;
      pos_q     <= 5'd0;
      found_q   <= 1'b0;
`ifdef SME_STAR_EN
      gap_q     <= 6'd0;
`endif
    end else begin
      state_q   <= state_d;
      str_len_q <= str_len_d;
      pat_len_q <= pat_len_d;
      pos_q     <= pos_d;
      found_q   <= found_d;
`ifdef SME_STAR_EN
      gap_q     <= gap_d;
`endif
    end
  end

  // NOTE: buffers are not reset; the stored lengths alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (str_we) str_mem_q[str_waddr] <= chardata;
    if (pat_we) pat_mem_q[pat_waddr] <= chardata;
  end

  assign valid       = (state_q == ST_DONE);
  assign match       = valid && found_q;
  assign match_index = match ? pos_q : 5'd0;

endmodule

// File: doc/str_match_engine.md
STR_MATCH_ENGINE -- requirements
Module: str_match_engine

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; low clears all state immediately.
REQ-003 SHALL have port chardata, input, 8, ASCII character sampled on clk while isstring or ispattern is high.
REQ-004 SHALL have port isstring, input, 1, high marks chardata as a string character, one per cycle.
REQ-005 SHALL have port ispattern, input, 1, high marks chardata as a pattern character, one per cycle.
REQ-006 SHALL have port valid, output, 1, one-cycle pulse marking match and match_index as the result.
REQ-007 SHALL have port match, output, 1, 1 = pattern found in the stored string.
REQ-008 SHALL have port match_index, output, 5, string index of the first matched character; meaningful only when match=1.

Function
REQ-009 SHALL store string characters in a 32x8 buffer, index 0 first; string length 1..32; characters beyond 32 are dropped.
REQ-010 SHALL clear the stored string on the first isstring cycle that follows a non-isstring cycle.
REQ-011 SHALL store pattern characters in an 8x8 buffer; pattern length 1..8; characters beyond 8 are dropped.
REQ-012 SHALL give isstring priority when isstring and ispattern are high in the same cycle.
REQ-013 SHALL run FSM IDLE -> LOAD_STR (isstring) / LOAD_PAT (ispattern); LOAD_PAT -> SEARCH on the first cycle ispattern is low; SEARCH -> DONE -> IDLE.
REQ-014 SHALL ignore chardata, isstring and ispattern in SEARCH and DONE.
REQ-015 SHALL keep the stored string across patterns; each pattern without a new string SHALL search the last stored string.
REQ-016 SHALL treat '.' (0x2E) in a pattern as matching any single character.
REQ-017 SHALL treat a leading '^' (0x5E) as matching string start or a space (0x20); when it matches a space, match_index SHALL point at the character after that space.
REQ-018 SHALL treat a trailing '$' (0x24) as matching string end or a space; a '$' that matches a space SHALL consume that space.
REQ-019 SHALL test one candidate start position per SEARCH cycle, ascending from 0, comparing all pattern positions in parallel.
REQ-020 SHALL report the lowest matching start position.
REQ-021 SHALL pulse valid for exactly one cycle in DONE, no later than 35 cycles after ispattern falls.
REQ-022 SHALL drive match=0 and match_index=0 whenever valid=0.
REQ-023 SHALL report match=0 if no string is stored, or if the pattern, excluding '^' and '$', is longer than the string.

Reset
REQ-024 SHALL drive valid=0, match=0 and match_index=0 while reset is low, enter IDLE, and set both stored lengths to 0.
REQ-025 SHALL abort any load or search when reset is asserted mid-operation and SHALL NOT emit valid for the aborted operation.

Configuration
REQ-026 SHALL compile '*' (0x2A) support only when SME_STAR_EN is defined; a pattern SHALL contain at most one '*'.
REQ-027 With SME_STAR_EN defined, '*' SHALL match zero or more characters, and valid SHALL come no later than 1100 cycles after ispattern falls.
REQ-028 Without SME_STAR_EN, '*' SHALL be a literal character and the latency bound of REQ-021 SHALL apply.

Verification
REQ-029 Load string "hello world", then pattern "wor" -> one valid pulse, match=1, match_index=6.
REQ-030 Same string, patterns "^wor", then "lo$", then "xyz" -> (1,6), then (1,3), then (0,--).
REQ-031 String "hello world", patterns "h.l", then "abcdefghi" (9 chars, last dropped) -> (1,0), then (0,--).
REQ-032 String "hello world", pattern "he*ld" -> (1,0) with SME_STAR_EN defined; (0,--) without it.
REQ-033 Drive reset low during the 2nd pattern character -> valid stays 0 and all outputs are 0; a new string and pattern afterwards give the correct result.
REQ-034 After reset, pattern "a" with no string loaded -> valid pulse with match=0; valid is never high for two consecutive cycles.
